// File: rtl/mouse_cursor_tracker.sv
// PS/2 mouse packet assembler with frame-rate cursor integration.
// Decodes 3-byte packets into deltas/buttons and moves a clamped cursor once per frame.
module mouse_cursor_tracker #(
  parameter int MAX_X       = 640,
  parameter int MAX_Y       = 480,
  parameter int CURSOR_SIZE = 15,
  parameter int INIT_X      = 245,
  parameter int INIT_Y      = 245,
  parameter int TIMEOUT     = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_data,
  input  logic       frame_tick,
  output logic [8:0] xm,
  output logic [8:0] ym,
  output logic       left,
  output logic       right,
  output logic       packet_tick,
  output logic [9:0] cursor_x,
  output logic [9:0] cursor_y,
  output logic       sync_err
);

  localparam int GW = $clog2(TIMEOUT + 1);
  localparam logic [GW-1:0]      GAP_MAX = GW'(TIMEOUT);
  localparam logic signed [12:0] LIM_X   = 13'(MAX_X - CURSOR_SIZE);
  localparam logic signed [12:0] LIM_Y   = 13'(MAX_Y - CURSOR_SIZE);

  typedef enum logic [1:0] {WAIT_B1, WAIT_B2, WAIT_B3} state_t;

  // Only the byte-1 fields that matter downstream are kept.
  typedef struct packed {
    logic yov;
    logic xov;
    logic ys;
    logic xs;
    logic rb;
    logic lb;
  } hdr_t;

  state_t  state, state_nxt;
  hdr_t    hdr;
  logic [7:0]    b2;
  logic [GW-1:0] gap;
  logic timeout, take_b1, take_b2, done, bad_b1;

  logic [8:0]         pkt_xm, pkt_ym;
  logic signed [11:0] pkt_dx, pkt_dy, dx_base, dy_base;
  logic signed [11:0] dx_acc, dy_acc;
  logic signed [12:0] nx, ny;

  function automatic logic signed [11:0] sat_add(input logic signed [11:0] a,
                                                 input logic signed [11:0] b);
    logic signed [12:0] s;
    s = {a[11], a} + {b[11], b};
    if (s > 13'sd2047)       return 12'sh7ff;
    else if (s < -13'sd2048) return 12'sh800;
    else                     return s[11:0];
  endfunction

  function automatic logic [9:0] clamp(input logic signed [12:0] v,
                                       input logic signed [12:0] hi);
    if (v < 13'sd0)  return 10'd0;
    else if (v > hi) return hi[9:0];
    else             return v[9:0];
  endfunction

  // An expiring gap timer takes priority over a byte arriving in the same cycle.
  assign timeout = (state != WAIT_B1) && (gap == GAP_MAX);

  always_comb begin
    state_nxt = state;
    take_b1   = 1'b0;
    take_b2   = 1'b0;
    done      = 1'b0;
    bad_b1    = 1'b0;
    if (timeout) begin
      state_nxt = WAIT_B1;
    end else if (rx_done_tick) begin
      case (state)
        WAIT_B1: begin
          if (rx_data[3]) begin
            take_b1   = 1'b1;
            state_nxt = WAIT_B2;
          end else begin
            bad_b1 = 1'b1;
          end
        end
        WAIT_B2: begin
          take_b2   = 1'b1;
          state_nxt = WAIT_B3;
        end
        WAIT_B3: begin
          done      = 1'b1;
          state_nxt = WAIT_B1;
        end
        default: state_nxt = WAIT_B1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= WAIT_B1;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                           gap <= '0;
    else if (state == WAIT_B1 || timeout || rx_done_tick) gap <= '0;
    else                                                  gap <= gap + GW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hdr <= '0;
      b2  <= '0;
    end else if (timeout) begin
      hdr <= '0;
      b2  <= '0;
    end else begin
      if (take_b1) hdr <= '{yov: rx_data[7], xov: rx_data[6], ys: rx_data[5],
                            xs: rx_data[4], rb: rx_data[1], lb: rx_data[0]};
      if (take_b2) b2 <= rx_data;
    end
  end

  assign pkt_xm = {hdr.xs, b2};
  assign pkt_ym = {hdr.ys, rx_data};
  assign pkt_dx = hdr.xov ? 12'sd0 : {{3{pkt_xm[8]}}, pkt_xm};
  assign pkt_dy = hdr.yov ? 12'sd0 : {{3{pkt_ym[8]}}, pkt_ym};
  // A frame in the same cycle empties the accumulator before this packet lands.
  assign dx_base = frame_tick ? 12'sd0 : dx_acc;
  assign dy_base = frame_tick ? 12'sd0 : dy_acc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xm          <= '0;
      ym          <= '0;
      left        <= 1'b0;
      right       <= 1'b0;
      packet_tick <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      packet_tick <= done;
      sync_err    <= timeout | bad_b1;
      if (done) begin
        xm    <= pkt_xm;
        ym    <= pkt_ym;
        left  <= hdr.lb;
        right <= hdr.rb;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dx_acc <= '0;
      dy_acc <= '0;
    end else if (done) begin
      dx_acc <= sat_add(dx_base, pkt_dx);
      dy_acc <= sat_add(dy_base, pkt_dy);
    end else if (frame_tick) begin
      dx_acc <= '0;
      dy_acc <= '0;
    end
  end

  // PS/2 +Y points up while screen rows grow downward, hence the subtraction.
  assign nx = $signed({3'b000, cursor_x}) + $signed({dx_acc[11], dx_acc});
  assign ny = $signed({3'b000, cursor_y}) - $signed({dy_acc[11], dy_acc});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cursor_x <= 10'(INIT_X);
      cursor_y <= 10'(INIT_Y);
    end else if (frame_tick) begin
      cursor_x <= clamp(nx, LIM_X);
      cursor_y <= clamp(ny, LIM_Y);
    end
  end

endmodule

// File: tb/tb_mouse_cursor_tracker.sv
// Scoreboard bench: a byte-list reference model predicts packets, resync strobes
// and cursor positions; a monitor compares them as the DUT presents each output.
module tb_mouse_cursor_tracker;

  localparam int MAX_X = 640, MAX_Y = 480, CS = 15, IX = 245, IY = 245, TO = 40;
  localparam int LX = MAX_X - CS, LY = MAX_Y - CS;

  logic       clk = 1'b0, reset = 1'b1, rx_done_tick = 1'b0, frame_tick = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic [8:0] xm, ym;
  logic       left, right, packet_tick, sync_err;
  logic [9:0] cursor_x, cursor_y;

  mouse_cursor_tracker #(.MAX_X(MAX_X), .MAX_Y(MAX_Y), .CURSOR_SIZE(CS),
                         .INIT_X(IX), .INIT_Y(IY), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .rx_data(rx_data),
    .frame_tick(frame_tick), .xm(xm), .ym(ym), .left(left), .right(right),
    .packet_tick(packet_tick), .cursor_x(cursor_x), .cursor_y(cursor_y),
    .sync_err(sync_err));

  always #5 clk = ~clk;

  int errors = 0, checks = 0;

  // reference model state
  logic [7:0]  pend[$];
  int          idle_cnt = 0;
  int          cx = IX, cy = IY, ax = 0, ay = 0;
  logic [19:0] pq[$];
  int          sq[$];
  logic [19:0] cq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int clampi(input int v, input int hi);
    return (v < 0) ? 0 : (v > hi) ? hi : v;
  endfunction

  function automatic int sat(input int v);
    return (v > 2047) ? 2047 : (v < -2048) ? -2048 : v;
  endfunction

  function automatic int s9(input logic [8:0] v);
    return v[8] ? int'(v) - 512 : int'(v);
  endfunction

  // One clock of stimulus as seen by the model: frame first, then the byte.
  function automatic void mstep(input bit rx, input logic [7:0] d, input bit ft);
    logic [7:0] b1, b2;
    logic [8:0] x9, y9;
    if (ft) begin
      cx = clampi(cx + ax, LX);
      cy = clampi(cy - ay, LY);
      cq.push_back({10'(cx), 10'(cy)});
      ax = 0;
      ay = 0;
    end
    if (pend.size() != 0 && idle_cnt == TO) begin
      sq.push_back(1);
      pend.delete();
      idle_cnt = 0;
    end else if (rx) begin
      idle_cnt = 0;
      if (pend.size() == 0 && !d[3]) sq.push_back(1);
      else if (pend.size() < 2) pend.push_back(d);
      else begin
        b1 = pend[0];
        b2 = pend[1];
        x9 = {b1[4], b2};
        y9 = {b1[5], d};
        pq.push_back({x9, y9, b1[0], b1[1]});
        if (!b1[6]) ax = sat(ax + s9(x9));
        if (!b1[7]) ay = sat(ay + s9(y9));
        pend.delete();
      end
    end else if (pend.size() != 0) begin
      idle_cnt++;
    end
  endfunction

  task automatic cyc(input bit rx, input logic [7:0] d, input bit ft);
    @(posedge clk);
    #1;
    mstep(rx, d, ft);
    rx_done_tick = rx;
    rx_data      = d;
    frame_tick   = ft;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 8'h00, 1'b0);
  endtask

  task automatic pkt(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    cyc(1'b1, a, 1'b0);
    cyc(1'b1, b, 1'b0);
    cyc(1'b1, c, 1'b0);
  endtask

  task automatic frame();
    cyc(1'b0, 8'h00, 1'b1);
    idle(2);
  endtask

  task automatic do_reset();
    idle(3);
    @(posedge clk);
    #1;
    reset = 1'b1;
    rx_done_tick = 1'b0;
    frame_tick = 1'b0;
    #2;
    chk("rst_xm", 32'(xm), 0);
    chk("rst_ym", 32'(ym), 0);
    chk("rst_btn", {30'd0, left, right}, 0);
    chk("rst_strobes", {30'd0, packet_tick, sync_err}, 0);
    chk("rst_cursor", {12'd0, cursor_x, cursor_y}, {12'd0, 10'(IX), 10'(IY)});
    pend.delete(); pq.delete(); sq.delete(); cq.delete();
    idle_cnt = 0; cx = IX; cy = IY; ax = 0; ay = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // monitor
  logic frame_d = 1'b0;
  always @(posedge clk) frame_d <= frame_tick && !reset;

  always @(negedge clk) begin
    if (!reset) begin
      if (packet_tick) begin
        if (pq.size() == 0) begin
          checks++; errors++;
          $display("FAIL pkt_unexpected: xm=%0h ym=%0h with nothing expected", xm, ym);
        end else chk("packet", {12'd0, xm, ym, left, right}, {12'd0, pq.pop_front()});
      end
      if (sync_err) begin
        checks++;
        if (sq.size() == 0) begin
          errors++;
          $display("FAIL sync_unexpected: sync_err=1 expected none");
        end else void'(sq.pop_front());
      end
      if (frame_d) begin
        if (cq.size() == 0) begin
          checks++; errors++;
          $display("FAIL cursor_unexpected: frame with no expectation");
        end else chk("cursor", {12'd0, cursor_x, cursor_y}, {12'd0, cq.pop_front()});
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    do_reset();

    // basic packet and frame
    pkt(8'h09, 8'h05, 8'h03);
    idle(2);
    frame();
    chk("tp1_cursor", {12'd0, cursor_x, cursor_y}, {12'd0, 10'd250, 10'd242});

    // negative deltas, right button
    do_reset();
    pkt(8'h3A, 8'hF0, 8'hF0);
    idle(2);
    chk("tp2_xm", 32'(xm), 32'h1F0);
    frame();
    chk("tp2_cursor", {12'd0, cursor_x, cursor_y}, {12'd0, 10'd229, 10'd261});

    // resync on bad header
    cyc(1'b1, 8'h00, 1'b0);
    pkt(8'h08, 8'h01, 8'h00);
    frame();

    // gap timeout: long, exactly-at-expiry (byte dropped), and just-in-time
    cyc(1'b1, 8'h08, 1'b0);
    idle(TO + 5);
    pkt(8'h08, 8'h02, 8'h00);
    cyc(1'b1, 8'h08, 1'b0);
    idle(TO);
    cyc(1'b1, 8'h55, 1'b0);
    pkt(8'h08, 8'h02, 8'h00);
    cyc(1'b1, 8'h08, 1'b0);
    idle(TO - 1);
    cyc(1'b1, 8'h03, 1'b0);
    idle(TO - 1);
    cyc(1'b1, 8'h00, 1'b0);
    frame();

    // saturation and clamping
    do_reset();
    repeat (10) pkt(8'h08, 8'hFF, 8'h00);
    frame();
    chk("tp5_max_x", 32'(cursor_x), 625);
    repeat (10) pkt(8'h18, 8'h00, 8'h00);
    frame();
    chk("tp5_min_x", 32'(cursor_x), 0);
    pkt(8'h08, 8'h20, 8'h00);
    frame();
    pkt(8'h48, 8'h10, 8'h00);
    frame();
    chk("tp5_ovf_x", 32'(cursor_x), 32);
    repeat (10) pkt(8'h28, 8'h00, 8'h80);
    frame();
    pkt(8'h88, 8'h00, 8'h7F);
    frame();

    // packet completing on the frame cycle
    pkt(8'h08, 8'h10, 8'h00);
    cyc(1'b1, 8'h08, 1'b0);
    cyc(1'b1, 8'h10, 1'b0);
    cyc(1'b1, 8'h00, 1'b1);
    idle(2);
    frame();

    // reset mid-packet
    cyc(1'b1, 8'h08, 1'b0);
    cyc(1'b1, 8'h05, 1'b0);
    do_reset();
    pkt(8'h08, 8'h01, 8'h00);
    frame();

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      b = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 9) != 0) b[3] = 1'b1;
      repeat ($urandom_range(0, 3)) cyc(1'b0, 8'h00, $urandom_range(0, 7) == 0);
      cyc(1'b1, b, $urandom_range(0, 9) == 0);
      if ($urandom_range(0, 39) == 0) idle(TO + $urandom_range(0, 2));
    end
    idle(4);
    frame();

    idle(5);
    chk("pq_drained", pq.size(), 0);
    chk("sq_drained", sq.size(), 0);
    chk("cq_drained", cq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
